mem_arbiter: RTL

Shares one single-ported memory bus between the instruction-fetch requester and the load/store requester of the core. It sequences each access through a small state machine and arbitrates round-robin when both requesters are pending. It formats byte and halfword lanes, with sign or zero extension on reads and byte enables on writes. It rejects misaligned or illegal accesses and bounds every bus transaction with a timeout.

---
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory bus between instruction fetch and load/store.
// Latency: a legal access acks 2 cycles after its request at minimum; an illegal access acks after 1 cycle.
// Backpressure: requests are levels held until ack; requests seen outside IDLE wait; bus stalls end at TIMEOUT.
// Ports: clk_i/rstn_i; fetch side if_req_i/if_addr_i -> if_ack_o/if_rdata_o/if_err_o;
//        data side d_req_i/d_we_i/d_size_i/d_sext_i/d_addr_i/d_wdata_i -> d_ack_o/d_rdata_o/d_err_o;
//        bus side mem_req_o/mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o <- mem_rdata_i/mem_ack_i.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [1:0]  d_size_i,
    input  logic        d_sext_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

    // The counter reaching TIMEOUT ends the access, so the last waiting cycle is TIMEOUT-1.
    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_last_d;     // 1 = data was granted last
    logic        r_own_d;      // owner of the access in flight
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [1:0]  r_lane;
    logic [15:0] r_cnt;

    logic        w_any_req;
    logic        w_grant_d;
    logic        w_g_we;
    logic [1:0]  w_g_size;
    logic        w_g_sext;
    logic [31:0] w_g_addr;
    logic        w_g_illegal;
    logic [3:0]  w_g_be;
    logic [31:0] w_g_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_ext;
    logic        w_finish;
    logic        w_owner_d;
    logic        w_rsp_err;
    logic [31:0] w_rsp_rdata;

    // Grant selection and lane formatting of the access about to be latched.
    always_comb begin
        w_any_req = if_req_i | d_req_i;
        // Data wins when alone, or on a tie when fetch was granted last.
        w_grant_d = d_req_i & (~if_req_i | ~r_last_d);
        w_g_we    = w_grant_d & d_we_i;
        w_g_size  = w_grant_d ? d_size_i : 2'd2;
        w_g_sext  = w_grant_d & d_sext_i;
        w_g_addr  = w_grant_d ? d_addr_i : if_addr_i;
        case (w_g_size)
            2'd0: begin
                w_g_illegal = 1'b0;
                w_g_be      = 4'b0001 << w_g_addr[1:0];
                w_g_wdata   = {4{d_wdata_i[7:0]}};
            end
            2'd1: begin
                w_g_illegal = w_g_addr[0];
                w_g_be      = 4'b0011 << w_g_addr[1:0];
                w_g_wdata   = {2{d_wdata_i[15:0]}};
            end
            2'd2: begin
                w_g_illegal = |w_g_addr[1:0];
                w_g_be      = 4'hF;
                w_g_wdata   = d_wdata_i;
            end
            default: begin
                w_g_illegal = 1'b1;
                w_g_be      = 4'hF;
                w_g_wdata   = d_wdata_i;
            end
        endcase
        if (!w_g_we) begin
            w_g_be = 4'hF;
        end
    end

    // Load extraction from the latched lane; aligned words pass through unshifted.
    always_comb begin
        w_shift = mem_rdata_i >> {r_lane, 3'b000};
        case (r_size)
            2'd0:    w_ext = r_sext ? {{24{w_shift[7]}}, w_shift[7:0]} : {24'd0, w_shift[7:0]};
            2'd1:    w_ext = r_sext ? {{16{w_shift[15]}}, w_shift[15:0]} : {16'd0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Response for the access finishing this cycle: illegal grant in IDLE, or ack/timeout in BUS.
    always_comb begin
        w_finish    = 1'b0;
        w_owner_d   = r_own_d;
        w_rsp_err   = 1'b1;
        w_rsp_rdata = 32'd0;
        case (r_state)
            IDLE: begin
                w_finish  = w_any_req & w_g_illegal;
                w_owner_d = w_grant_d;
            end
            BUS: begin
                // An ack in the timeout cycle still completes normally.
                w_finish = mem_ack_i | (r_cnt == LP_CNT_LAST);
                if (mem_ack_i) begin
                    w_rsp_err   = 1'b0;
                    w_rsp_rdata = !r_own_d ? mem_rdata_i : (r_we ? 32'd0 : w_ext);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= IDLE;
            r_last_d    <= 1'b1;
            r_own_d     <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_sext      <= 1'b0;
            r_lane      <= 2'd0;
            r_cnt       <= 16'd0;
            if_ack_o    <= 1'b0;
            if_rdata_o  <= 32'd0;
            if_err_o    <= 1'b0;
            d_ack_o     <= 1'b0;
            d_rdata_o   <= 32'd0;
            d_err_o     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= 32'd0;
        end else begin
            if_ack_o <= 1'b0;
            d_ack_o  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_last_d <= w_grant_d;
                        r_own_d  <= w_grant_d;
                        r_we     <= w_g_we;
                        r_size   <= w_g_size;
                        r_sext   <= w_g_sext;
                        r_lane   <= w_g_addr[1:0];
                        if (w_g_illegal) begin
                            r_state <= DONE;
                        end else begin
                            r_state     <= BUS;
                            r_cnt       <= 16'd0;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= w_g_we;
                            mem_addr_o  <= {w_g_addr[31:2], 2'b00};
                            mem_be_o    <= w_g_be;
                            mem_wdata_o <= w_g_wdata;
                        end
                    end
                end
                BUS: begin
                    if (!mem_ack_i) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    if (w_finish) begin
                        r_state   <= DONE;
                        mem_req_o <= 1'b0;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_finish) begin
                if (w_owner_d) begin
                    d_ack_o   <= 1'b1;
                    d_err_o   <= w_rsp_err;
                    d_rdata_o <= w_rsp_rdata;
                end else begin
                    if_ack_o   <= 1'b1;
                    if_err_o   <= w_rsp_err;
                    if_rdata_o <= w_rsp_rdata;
                end
            end
        end
    end

endmodule
